mdu_ctrl: RTL and testbench

- Iterative multiply/divide unit with its own HI/LO registers and Funct decode. It generalises ALU control to multi-cycle MIPS ops: mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits beside the EX-stage ALU. It raises a stall to hazard control while busy and accepts a flush from the pipeline.

---
 rtl/mdu_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit with private HI/LO registers.
//
// Decodes the MIPS SPECIAL funct field for mult, multu, div, divu, mfhi,
// mflo, mthi and mtlo. Multiplies use radix-2 shift-add and divides use
// restoring division, one bit per cycle, followed by a single sign-fixup
// cycle that writes HI/LO and pulses done.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    EX-stage instruction is an MDU op
//   Funct    instruction funct field
//   op_a     rs value (dividend / multiplicand / mthi-mtlo data)
//   op_b     rt value (divisor / multiplier)
//   abort    pipeline flush, cancels the in-flight op
//   stall    start && op uses the unit && busy (combinational)
//   busy     unit is iterating or fixing up (registered)
//   done     one-cycle pulse after HI/LO were written by mult/div
//   rd_data  HI for mfhi, LO for mflo while idle, else 0
//   hi, lo   HI and LO registers
//
// Build option: define MDU_EARLY_TERM_EN to end a multiply as soon as the
// remaining multiplier bits are all zero. Divides always run full length.
module mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;  // multiplicand magnitude, moves left each step
  logic [WIDTH-1:0] opb_q, opb_d;      // multiplier (moves right) or divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;      // product, or {remainder, dividend->quotient}
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;      // product / quotient must be negated
  logic             rneg_q, rneg_d;    // remainder takes the dividend's sign
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, is_md, uses_unit;
  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg_2w(input logic [W2-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign is_mul    = (Funct[5:1] == 5'b01100);
  assign is_div    = (Funct[5:1] == 5'b01101);
  assign is_mfhi   = (Funct == 6'b010000);
  assign is_mflo   = (Funct == 6'b010010);
  assign is_mthi   = (Funct == 6'b010001);
  assign is_mtlo   = (Funct == 6'b010011);
  assign is_md     = is_mul | is_div;
  assign uses_unit = is_md | is_mfhi | is_mflo | is_mthi | is_mtlo;

  assign sgn   = ~Funct[0];
  assign abs_a = mag_w(op_a, sgn);
  assign abs_b = mag_w(op_b, sgn);

  // Restoring step: bring the next dividend bit into the partial remainder
  // and keep the subtraction only if it did not go negative.
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_q};

  // Divide by zero naturally leaves remainder = |dividend|; only the
  // quotient needs forcing to all ones.
  assign prod_fix = cond_neg_2w(acc_q, neg_q);
  assign quo_fix  = (opb_q == '0) ? '1 : cond_neg_w(acc_q[WIDTH-1:0], neg_q);
  assign rem_fix  = cond_neg_w(acc_q[W2-1:WIDTH], rneg_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (is_md) begin
            state_d  = is_div ? S_DIV : S_MUL;
            cnt_d    = CNT_W'(WIDTH - 1);
            mcand_d  = {{WIDTH{1'b0}}, abs_a};
            opb_d    = abs_b;
            acc_d    = is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
            op_div_d = is_div;
            neg_d    = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_d   = sgn & op_a[WIDTH-1];
          end else if (is_mthi) begin
            hi_d = op_a;
          end else if (is_mtlo) begin
            lo_d = op_a;
          end
        end
      end
      S_MUL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (opb_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIXUP;
`ifdef MDU_EARLY_TERM_EN
          // Remaining multiplier bits are zero: further steps add nothing.
          else if (opb_q[WIDTH-1:1] == '0) state_d = S_FIXUP;
`endif
        end
      end
      S_DIV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!abort) begin
          done_d = 1'b1;
          if (op_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = start && uses_unit && busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    rd_data = '0;
    if (start && !busy) begin
      if (is_mfhi)      rd_data = hi_q;
      else if (is_mflo) rd_data = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed cases plus randomized back-to-back
// mult/div traffic compared against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [5:0]   Funct;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, done;
  logic [W-1:0] rd_data, hi, lo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct(Funct),
    .op_a(op_a), .op_b(op_b), .abort(abort),
    .stall(stall), .busy(busy), .done(done),
    .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eh, output logic [W-1:0] el);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = int'(a);
    sb = int'(b);
    eh = '0;
    el = '0;
    if (f == F_MULT) begin
      sp = longint'(sa) * longint'(sb);
      {eh, el} = sp;
    end else if (f == F_MULTU) begin
      up = {32'h0, a};
      up = up * {32'h0, b};
      {eh, el} = up;
    end else if (b == 0) begin
      el = 32'hFFFF_FFFF;
      eh = a;
    end else if (f == F_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = a;
        eh = '0;
      end else begin
        el = sa / sb;
        eh = sa % sb;
      end
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  // Edge index (after the accepting edge) at which done is expected.
  function automatic int exp_latency(input logic [5:0] f, input logic [W-1:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0] mag;
    int k;
    if (f == F_DIV || f == F_DIVU) return W + 1;
    mag = (f == F_MULT && b[W-1]) ? -b : b;
    k = 0;
    for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
    return ((k < 1) ? 1 : k) + 1;
`else
    return W + 1;
`endif
  endfunction

  // Issue one mult/div and follow it to its done pulse; returns in the done cycle.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eh, el;
    int lat, n, busy_cnt;
    bit seen;
    ref_op(f, a, b, eh, el);
    lat = exp_latency(f, b);
    start = 1'b1; Funct = f; op_a = a; op_b = b;
    tick;
    start = 1'b0; Funct = '0; op_a = '0; op_b = '0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", tag, busy, done);
    else passed++;
    busy_cnt = busy ? 1 : 0;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      tick;
      n++;
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    total++;
    if (!seen) $display("FAIL %s timeout: no done within 100 cycles", tag);
    else passed++;
    total++;
    if (n !== lat) $display("FAIL %s done_edge: got E%0d required E%0d", tag, n, lat);
    else passed++;
    total++;
    if (busy_cnt !== lat) $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy_cnt, lat);
    else passed++;
    total++;
    if (hi !== eh || lo !== el)
      $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", tag, hi, lo, eh, el);
    else passed++;
  endtask

  task automatic write_hl(input logic [5:0] f, input logic [W-1:0] v);
    start = 1'b1; Funct = f; op_a = v;
    tick;
    start = 1'b0; Funct = '0; op_a = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; Funct = '0; op_a = '0; op_b = '0;
    #12;
    total++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b required all 0", hi, lo, busy, done, stall);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick;
  endtask

  task automatic test_read(input logic [W-1:0] eh, input logic [W-1:0] el, input string tag);
    start = 1'b1; Funct = F_MFHI;
    #1;
    total++;
    if (rd_data !== eh || stall !== 1'b0)
      $display("FAIL %s mfhi: rd_data=%h stall=%b required %h stall=0", tag, rd_data, stall, eh);
    else passed++;
    Funct = F_MFLO;
    #1;
    total++;
    if (rd_data !== el || stall !== 1'b0)
      $display("FAIL %s mflo: rd_data=%h stall=%b required %h stall=0", tag, rd_data, stall, el);
    else passed++;
    start = 1'b0; Funct = '0;
  endtask

  task automatic test_directed;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1)
      $display("FAIL mult_neg3x5_const: hi=%h lo=%h required ffffffff fffffff1", hi, lo);
    else passed++;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    test_read(32'hFFFF_FFFE, 32'h0000_0001, "after_multu");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("FAIL div_neg7by2_const: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
    else passed++;
    run_op(F_DIVU, 32'd7, 32'd0, "divu_by0");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
    total++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000)
      $display("FAIL div_min_neg1_const: hi=%h lo=%h required 00000000 80000000", hi, lo);
    else passed++;
  endtask

  task automatic test_early_term;
    run_op(F_MULTU, 32'd7, 32'd1, "multu_7x1");
    run_op(F_MULT, 32'd3, 32'd0, "mult_3x0");
    run_op(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_neg1");
  endtask

  task automatic test_mthi_mtlo;
    logic [W-1:0] vh, vl;
    vh = $urandom;
    vl = $urandom;
    write_hl(F_MTHI, vh);
    write_hl(F_MTLO, vl);
    total++;
    if (hi !== vh || lo !== vl || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL mthi_mtlo: hi=%h lo=%h done=%b busy=%b required %h %h 0 0", hi, lo, done, busy, vh, vl);
    else passed++;
    test_read(vh, vl, "after_mt");
  endtask

  task automatic test_busy_abort;
    logic [W-1:0] sh, sl;
    bit seen;
    sh = hi; sl = lo;
    start = 1'b1; Funct = F_DIV; op_a = $urandom; op_b = $urandom_range(1, 1000);
    tick;
    start = 1'b0; Funct = '0;
    repeat (4) tick;
    start = 1'b1; Funct = F_MFLO;
    #1;
    total++;
    if (stall !== 1'b1 || rd_data !== '0)
      $display("FAIL busy_mflo: stall=%b rd_data=%h required stall=1 rd_data=0", stall, rd_data);
    else passed++;
    Funct = 6'b100000;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL busy_nonmdu_stall: stall=%b required 0", stall);
    else passed++;
    Funct = F_MTHI; op_a = 32'hDEAD_BEEF;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL busy_mthi_stall: stall=%b required 1", stall);
    else passed++;
    repeat (4) tick;
    start = 1'b0; Funct = '0; abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== sh || lo !== sl)
      $display("FAIL abort_busy: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, sh, sl);
    else passed++;
    seen = 0;
    repeat (40) begin
      tick;
      if (done) seen = 1;
    end
    total++;
    if (seen || hi !== sh || lo !== sl)
      $display("FAIL abort_no_done: done_seen=%0d hi=%h lo=%h required 0 %h %h", seen, hi, lo, sh, sl);
    else passed++;
  endtask

  task automatic test_abort_start;
    logic [W-1:0] sl;
    sl = lo;
    abort = 1'b1;
    start = 1'b1; Funct = F_MULT; op_a = 32'd9; op_b = 32'd9;
    tick;
    total++;
    if (busy !== 1'b0) $display("FAIL abort_start_mult: busy=%b required 0", busy);
    else passed++;
    Funct = F_MTLO; op_a = ~sl;
    tick;
    start = 1'b0; abort = 1'b0; Funct = '0;
    total++;
    if (lo !== sl) $display("FAIL abort_start_mtlo: lo=%h required %h", lo, sl);
    else passed++;
  endtask

  task automatic test_abort_fixup;
    logic [W-1:0] sh, sl;
    sh = hi; sl = lo;
    start = 1'b1; Funct = F_DIVU; op_a = 32'd100; op_b = 32'd7;
    tick;
    start = 1'b0; Funct = '0;
    repeat (W) tick;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL fixup_reached: busy=%b done=%b required 1 0", busy, done);
    else passed++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== sh || lo !== sl)
      $display("FAIL abort_fixup: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", busy, done, hi, lo, sh, sl);
    else passed++;
  endtask

  task automatic test_async_reset;
    write_hl(F_MTHI, 32'hA5A5_A5A5);
    write_hl(F_MTLO, 32'h5A5A_5A5A);
    start = 1'b1; Funct = F_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    tick;
    start = 1'b0; Funct = '0;
    repeat (11) tick;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b required 0 0 0 0", hi, lo, busy, done);
    else passed++;
    tick;
    reset = 1'b1;
    write_hl(F_MTLO, 32'h0000_1234);
    total++;
    if (lo !== 32'h0000_1234 || hi !== '0 || busy !== 1'b0)
      $display("FAIL mtlo_after_reset: lo=%h hi=%h busy=%b required 00001234 0 0", lo, hi, busy);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [5:0]   f;
    logic [W-1:0] a, b;
    string tag;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1, 2: b = $urandom_range(0, 15);
        3: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (i == 5) begin f = F_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      tag = $sformatf("rand%0d_f%b", i, f);
      run_op(f, a, b, tag);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_early_term;
    test_mthi_mtlo;
    test_busy_abort;
    test_abort_start;
    test_abort_fixup;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
